// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/note-off events onto VOICES voices,
// reusing idle voices first, then releasing ones, then stealing the oldest gated one.
module voice_alloc #(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7,
  parameter int VEL_BITS  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_BITS-1:0]          ev_note,
  input  logic [VEL_BITS-1:0]           ev_velocity,
  input  logic [VOICES-1:0]             voice_active,
  output logic [VOICES-1:0]             gate,
  output logic [VOICES*NOTE_BITS-1:0]   note,
  output logic [VOICES*VEL_BITS-1:0]    velocity
);

  localparam int RW = $clog2(VOICES);

  typedef enum logic [1:0] {IDLE, DECIDE, ASSIGN} state_t;

  state_t               state_q;
  logic                 ready_q;
  logic [VOICES-1:0]    gate_q;
  logic [NOTE_BITS-1:0] note_q [VOICES];
  logic [VEL_BITS-1:0]  vel_q  [VOICES];
  logic [RW-1:0]        rank_q [VOICES];
  logic                 lat_on_q;
  logic [NOTE_BITS-1:0] lat_note_q;
  logic [VEL_BITS-1:0]  lat_vel_q;
  logic [RW-1:0]        target_q;

  logic [VOICES-1:0]    match_vec;
  logic [VOICES-1:0]    idle_vec;
  logic [VOICES-1:0]    rel_vec;

  logic                 match_any, idle_any, rel_any, steal_any;
  logic [RW-1:0]        match_idx, idle_idx, rel_idx, steal_idx;
  logic [RW-1:0]        rel_rank, steal_rank;
  logic [RW-1:0]        target_d;

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice
      assign match_vec[gi] = gate_q[gi] && (note_q[gi] == lat_note_q);
      assign idle_vec[gi]  = !gate_q[gi] && !voice_active[gi];
      assign rel_vec[gi]   = !gate_q[gi] && voice_active[gi];
      assign note[gi*NOTE_BITS +: NOTE_BITS]   = note_q[gi];
      assign velocity[gi*VEL_BITS +: VEL_BITS] = vel_q[gi];
    end
  endgenerate

  assign gate     = gate_q;
  assign ev_ready = ready_q;

  // Descending scan leaves the lowest index; ascending scan keeps the highest rank.
  always_comb begin
    match_any  = 1'b0;
    match_idx  = '0;
    idle_any   = 1'b0;
    idle_idx   = '0;
    rel_any    = 1'b0;
    rel_idx    = '0;
    rel_rank   = '0;
    steal_any  = 1'b0;
    steal_idx  = '0;
    steal_rank = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_any = 1'b1;
        match_idx = RW'(i);
      end
      if (idle_vec[i]) begin
        idle_any = 1'b1;
        idle_idx = RW'(i);
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      if (rel_vec[i] && (!rel_any || rank_q[i] > rel_rank)) begin
        rel_any  = 1'b1;
        rel_idx  = RW'(i);
        rel_rank = rank_q[i];
      end
      if (gate_q[i] && (!steal_any || rank_q[i] > steal_rank)) begin
        steal_any  = 1'b1;
        steal_idx  = RW'(i);
        steal_rank = rank_q[i];
      end
    end
  end

  always_comb begin
    if (match_any)     target_d = match_idx;
    else if (idle_any) target_d = idle_idx;
    else if (rel_any)  target_d = rel_idx;
    else               target_d = steal_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      gate_q     <= '0;
      lat_on_q   <= 1'b0;
      lat_note_q <= '0;
      lat_vel_q  <= '0;
      target_q   <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= RW'(i);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_valid && ready_q) begin
            lat_note_q <= ev_note;
            lat_vel_q  <= ev_velocity;
            // A zero-velocity note-on is a note-off in MIDI running-status practice.
            lat_on_q   <= ev_on && (ev_velocity != '0);
            ready_q    <= 1'b0;
            state_q    <= DECIDE;
          end
        end
        DECIDE: begin
          if (lat_on_q) begin
            target_q <= target_d;
            // Drop a gated target for one cycle so the envelope restarts its attack.
            if (gate_q[target_d]) gate_q[target_d] <= 1'b0;
            state_q <= ASSIGN;
          end else begin
            gate_q  <= gate_q & ~match_vec;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        ASSIGN: begin
          gate_q[target_q] <= 1'b1;
          note_q[target_q] <= lat_note_q;
          vel_q[target_q]  <= lat_vel_q;
          for (int i = 0; i < VOICES; i++) begin
            if (RW'(i) == target_q)              rank_q[i] <= '0;
            else if (rank_q[i] < rank_q[target_q]) rank_q[i] <= rank_q[i] + 1'b1;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice allocator; sits directly upstream of the per-voice adsr envelope generators.
- Consumes a stream of note-on/note-off events from the MIDI decoder through a valid/ready handshake.
- Drives each voice's gate, note number and velocity. The gate feeds the adsr gate input; note and velocity feed the oscillator and the DCA.
- Uses each adsr's active output to tell idle voices from releasing ones, and steals the oldest voice when all voices are busy.

Parameters:
VOICES, 4, number of voices (2..16)
NOTE_BITS, 7, width of a note number
VEL_BITS, 7, width of a velocity

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept an event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  NOTE_BITS  event note number
ev_velocity  in  VEL_BITS  event velocity
voice_active  in  VOICES  per-voice adsr active flag
gate  out  VOICES  per-voice gate to adsr
note  out  VOICES*NOTE_BITS  per-voice note; voice i occupies [i*NOTE_BITS +: NOTE_BITS]
velocity  out  VOICES*VEL_BITS  per-voice velocity, packed the same way

Behaviour:
- Reset (reset==0, asynchronous):
  - gate=0, note=0, velocity=0, ev_ready=1, state=IDLE.
  - Age rank of voice i = i (rank 0 = newest, VOICES-1 = oldest).
  - Reset mid-operation abandons the pending event; it is not replayed.
- Handshake:
  - ev_ready = (state==IDLE).
  - An event is accepted on the clk edge E0 at which ev_valid && ev_ready; ev_note, ev_velocity and ev_on are latched at E0.
  - ev_ready is low from E0 until the allocator returns to IDLE.
  - ev_on=1 with ev_velocity==0 is treated as a note-off.
- States:
  - IDLE: wait for an accepted event -> DECIDE.
  - DECIDE: select target voice(s) using voice_active and gate as sampled in this cycle.
    - Note-off, at E1: clear gate of every voice with gate=1 and note==latched note; -> IDLE. No match: no change, -> IDLE.
    - Note-on, at E1: register target index. If the target's gate=1, clear its gate at E1. -> ASSIGN.
  - ASSIGN: at E2 set target gate=1, note and velocity = latched values; update ranks; -> IDLE.
- Note-on latency and throughput:
  - gate high is visible after E2 in every case.
  - A gated target is held low for exactly the E1..E2 cycle, so the downstream adsr sees the 1->0->1 edges and restarts attack.
  - Throughput: note-on 1 event / 3 cycles; note-off 1 event / 2 cycles.
- Target priority for note-on (first match wins):
  1. A voice with gate=1 and the same note (retrigger); lowest index if several.
  2. Idle voice (gate=0, voice_active=0); lowest index.
  3. Releasing voice (gate=0, voice_active=1) with highest rank.
  4. Gated voice with highest rank (steal).
- Rank update on ASSIGN:
  - Let r = the target's old rank. Every voice with rank < r increments by 1; the target gets rank 0.
  - Ranks always remain a permutation of 0..VOICES-1. Note-off never changes ranks.
- note and velocity hold their last values after gate falls, so release continues at the correct pitch.
- voice_active is consulted only in DECIDE; changes in other cycles have no effect.
- Rank comparison and priority search are combinational over VOICES; no arithmetic wider than clog2(VOICES).

Test Plan:
- Reset, then note-on 60 vel 100 accepted at E0 -> gate[0]=1, note[0]=60, velocity[0]=100 after E2; ev_ready low for cycles E0..E2, high after E2.
- Note-on 60/62/64/67 (voice_active all 0), then note-off 62 -> voices 0..3 gated with those notes; after note-off, gate=4'b1101.
- With voice_active=4'b0010 and gate=4'b1101, note-on 70 -> voice 1 (releasing) is reused; its gate goes 0->1 after E2.
- All four gated (allocation order 0,1,2,3), note-on 72 -> voice 0 stolen: gate[0]=0 in cycle E1..E2, then 1 with note[0]=72 after E2; ranks become v0=0, v1=3, v2=2, v3=1.
- Note-on 60 while voice 0 holds gated 60, new velocity 50 -> voice 0 retriggered (one-cycle low gate), velocity[0]=50, no other voice changes; note-on 65 vel 0 -> handled as note-off, nothing allocated.
- Assert reset while in ASSIGN -> all outputs 0 immediately, ev_ready=1; after release, the next event allocates voice 0.
